// File: rtl/sensor_i2c_scheduler.sv
// sensor_i2c_scheduler
// Round-robin scheduler sharing one byte-level I2C master core among NUM_REQ
// requesters. Each grant runs one single-register read or write. The grant
// sequence is IDLE -> ARB -> ISSUE -> WAIT -> COMPLETE.
// Optional feature macro: I2C_SCHED_TIMEOUT_EN. When it is defined, a
// watchdog in WAIT aborts a transaction that the master never completes.
// When it is undefined, no counter is built and m_abort stays 0.
`timescale 1ns/1ps
module sensor_i2c_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [7*NUM_REQ-1:0] req_addr,
   input  logic [8*NUM_REQ-1:0] req_reg,
   input  logic [NUM_REQ-1:0]   req_rnw,
   input  logic [8*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   done,
   output logic [NUM_REQ-1:0]   err,
   output logic [7:0]           rdata,
   output logic                 m_start,
   output logic [6:0]           m_addr,
   output logic [7:0]           m_reg,
   output logic                 m_rnw,
   output logic [7:0]           m_wdata,
   output logic                 m_abort,
   input  logic                 m_busy,
   input  logic                 m_done,
   input  logic                 m_ack_err,
   input  logic [7:0]           m_rdata
);

   localparam int PW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("sensor_i2c_scheduler: NUM_REQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("sensor_i2c_scheduler: TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARB      = 3'd1,
      S_ISSUE    = 3'd2,
      S_WAIT     = 3'd3,
      S_COMPLETE = 3'd4
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [PW-1:0]      ptr;
   logic [PW-1:0]      ptr_d;
   logic [PW-1:0]      sel;
   logic [PW-1:0]      sel_d;
   logic [NUM_REQ-1:0] gnt_d;
   logic [NUM_REQ-1:0] done_d;
   logic [NUM_REQ-1:0] err_d;
   logic [7:0]         rdata_d;
   logic               m_start_d;
   logic               m_abort_d;
   logic [6:0]         m_addr_d;
   logic [7:0]         m_reg_d;
   logic               m_rnw_d;
   logic [7:0]         m_wdata_d;
   logic               arb_found;
   logic [PW-1:0]      arb_idx;
   logic               wd_expire;

   // Round-robin pick: first set req bit at or above ptr, wrapping around
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!arb_found && req[(int'(ptr) + k) % NUM_REQ]) begin
            arb_found = 1'b1;
            arb_idx   = PW'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end

`ifdef I2C_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] wd_cnt;

   // Watchdog counts WAIT cycles; it is zero outside WAIT, so it starts at 0 on entry
   always_ff @(posedge clk) begin
      if (reset || state != S_WAIT) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign wd_expire = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign wd_expire = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; ARB falls back to IDLE if every request vanished meanwhile
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (|req) state_nxt = S_ARB;
         S_ARB:      state_nxt = arb_found ? S_ISSUE : S_IDLE;
         S_ISSUE:    if (!m_busy) state_nxt = S_WAIT;
         S_WAIT:     if (m_done || wd_expire) state_nxt = S_COMPLETE;
         S_COMPLETE: state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Output/next-register values; done/err/rdata are staged so they appear in COMPLETE
   always_comb begin
      gnt_d     = gnt;
      sel_d     = sel;
      ptr_d     = ptr;
      m_addr_d  = m_addr;
      m_reg_d   = m_reg;
      m_rnw_d   = m_rnw;
      m_wdata_d = m_wdata;
      done_d    = '0;
      err_d     = '0;
      rdata_d   = 8'h00;
      m_start_d = 1'b0;
      m_abort_d = 1'b0;
      case (state)
         S_ARB: begin
            if (arb_found) begin
               gnt_d     = NUM_REQ'(1) << arb_idx;
               sel_d     = arb_idx;
               m_addr_d  = req_addr[int'(arb_idx)*7 +: 7];
               m_reg_d   = req_reg[int'(arb_idx)*8 +: 8];
               m_rnw_d   = req_rnw[arb_idx];
               m_wdata_d = req_wdata[int'(arb_idx)*8 +: 8];
            end
         end
         S_ISSUE: begin
            m_start_d = !m_busy;
         end
         S_WAIT: begin
            // A completion in the same cycle as the watchdog expiry wins
            if (m_done) begin
               done_d  = gnt;
               err_d   = m_ack_err ? gnt : '0;
               rdata_d = m_rnw ? m_rdata : 8'h00;
            end else if (wd_expire) begin
               done_d    = gnt;
               err_d     = gnt;
               m_abort_d = 1'b1;
            end
         end
         S_COMPLETE: begin
            gnt_d = '0;
            ptr_d = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
         end
         default: begin
            gnt_d = '0;
         end
      endcase
   end

   // Output and master-side registers; every output leaves the block from a flop
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt     <= '0;
         sel     <= '0;
         ptr     <= '0;
         done    <= '0;
         err     <= '0;
         rdata   <= 8'h00;
         m_start <= 1'b0;
         m_abort <= 1'b0;
         m_addr  <= 7'h00;
         m_reg   <= 8'h00;
         m_rnw   <= 1'b0;
         m_wdata <= 8'h00;
      end else begin
         gnt     <= gnt_d;
         sel     <= sel_d;
         ptr     <= ptr_d;
         done    <= done_d;
         err     <= err_d;
         rdata   <= rdata_d;
         m_start <= m_start_d;
         m_abort <= m_abort_d;
         m_addr  <= m_addr_d;
         m_reg   <= m_reg_d;
         m_rnw   <= m_rnw_d;
         m_wdata <= m_wdata_d;
      end
   end

endmodule
